// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy count, watermark flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; otherwise DATAOUT is registered (1-cycle latency).
module sync_fifo_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wn,
   input  logic                     rn,
   input  logic [WIDTH-1:0]         DATAIN,
   output logic [WIDTH-1:0]         DATAOUT,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_THRESH  = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_THRESH  = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_reg;
   logic [AW-1:0]    rptr_reg;
   logic [CW-1:0]    count_reg;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             wr_ok;
   logic             rd_ok;

   assign empty        = (count_reg == '0);
   assign full         = (count_reg == FULL_LEVEL);
   assign almost_full  = (count_reg >= AF_THRESH);
   assign almost_empty = (count_reg <= AE_THRESH);
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // A read at full frees the head slot on the same edge, so the write may proceed.
   assign rd_ok = rn & ~empty;
   assign wr_ok = wn & (~full | rd_ok);

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem[wptr_reg] <= DATAIN;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         overflow_reg  <= wn & ~wr_ok;
         underflow_reg <= rn & ~rd_ok;
         if (wr_ok) begin
            wptr_reg <= wptr_reg + AW'(1);
         end
         if (rd_ok) begin
            rptr_reg <= rptr_reg + AW'(1);
         end
         if (wr_ok && !rd_ok) begin
            count_reg <= count_reg + CW'(1);
         end else if (rd_ok && !wr_ok) begin
            count_reg <= count_reg - CW'(1);
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign DATAOUT = empty ? '0 : mem[rptr_reg];
`else
   logic [WIDTH-1:0] dout_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dout_reg <= '0;
      end else if (rd_ok) begin
         dout_reg <= mem[rptr_reg];
      end
   end

   assign DATAOUT = dout_reg;
`endif

endmodule
